// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/response and data-memory bus for the load/store responder
interface mem_access_unit_if;
  logic req, we, busy, done, err, mem_wr;
  logic [2:0] func3;
  logic [63:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
  modport master (output req, we, func3, addr, wdata, mem_rdata,
                  input busy, done, err, rdata, mem_addr, mem_wr, mem_wdata);
  modport slave (input req, we, func3, addr, wdata, mem_rdata,
                 output busy, done, err, rdata, mem_addr, mem_wr, mem_wdata);
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle RV64 load/store responder with read-modify-write narrow stores
module mem_access_unit #(
  parameter int READ_LAT = 1
) (
  input logic clk,
  input logic reset,
  mem_access_unit_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD_WAIT, WRITE, DONE, ERR} state_t;
  state_t r_state, w_next;
  logic [2:0] r_cnt, r_f3;
  logic r_we;
  logic [63:0] r_addr, r_mwdata, r_rdata;
  logic w_bad, w_sd, w_last;
  logic [5:0] w_sh;
  logic [63:0] w_lane, w_ext, w_mask, w_merged;
  assign w_bad = (bus.we ? bus.func3[2] : &bus.func3)
               | (bus.func3[1:0] == 2'd1 & bus.addr[0])
               | (bus.func3[1:0] == 2'd2 & |bus.addr[1:0])
               | (bus.func3[1:0] == 2'd3 & |bus.addr[2:0]);
  assign w_sd = bus.we & (bus.func3 == 3'b011);
  assign w_last = (r_cnt == 3'd0);
  assign w_sh = {r_addr[2:0], 3'b000};
  assign w_lane = bus.mem_rdata >> w_sh;
  assign w_ext = r_f3 == 3'd0 ? {{56{w_lane[7]}}, w_lane[7:0]}
               : r_f3 == 3'd1 ? {{48{w_lane[15]}}, w_lane[15:0]}
               : r_f3 == 3'd2 ? {{32{w_lane[31]}}, w_lane[31:0]}
               : r_f3 == 3'd4 ? {56'd0, w_lane[7:0]}
               : r_f3 == 3'd5 ? {48'd0, w_lane[15:0]}
               : r_f3 == 3'd6 ? {32'd0, w_lane[31:0]}
               : w_lane;
  assign w_mask = (r_f3[1:0] == 2'd0 ? 64'hFF : r_f3[1:0] == 2'd1 ? 64'hFFFF : 64'hFFFF_FFFF) << w_sh;
  // r_mwdata holds the captured store data until it is replaced by the merged doubleword
  assign w_merged = (bus.mem_rdata & ~w_mask) | ((r_mwdata << w_sh) & w_mask);
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = !bus.req ? IDLE : w_bad ? ERR : w_sd ? WRITE : RD_WAIT;
      RD_WAIT: w_next = !w_last ? RD_WAIT : r_we ? WRITE : DONE;
      WRITE:   w_next = DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt <= 3'd0;
      r_we <= 1'b0;
      r_f3 <= 3'd0;
      r_addr <= 64'd0;
      r_mwdata <= 64'd0;
      r_rdata <= 64'd0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && bus.req) begin
        r_we <= bus.we;
        r_f3 <= bus.func3;
        r_addr <= bus.addr;
        r_mwdata <= bus.wdata;
        r_cnt <= 3'(READ_LAT);
      end else if (r_state == RD_WAIT) begin
        if (!w_last) r_cnt <= r_cnt - 3'd1;
        else if (r_we) r_mwdata <= w_merged;
        else r_rdata <= w_ext;
      end
    end
  end
  assign bus.busy = (r_state != IDLE);
  assign bus.done = (r_state == DONE) | (r_state == ERR);
  assign bus.err = (r_state == ERR);
  assign bus.mem_wr = (r_state == WRITE);
  assign bus.mem_addr = {r_addr[63:3], 3'b000};
  assign bus.mem_wdata = r_mwdata;
  assign bus.rdata = r_rdata;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of mem_access_unit against a READ_LAT=2 memory model
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [63:0] mem [256];
  logic [63:0] p0, p1;
  int d_cyc, w_cnt, w_cyc, extra;
  logic d_err, b_after;
  logic [63:0] w_dat;
  mem_access_unit_if bus();
  mem_access_unit #(.READ_LAT(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign bus.mem_rdata = p1;
  always @(posedge clk) begin
    p0 <= mem[bus.mem_addr[10:3]];
    p1 <= p0;
    if (bus.mem_wr) mem[bus.mem_addr[10:3]] <= bus.mem_wdata;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic access(input logic we, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd,
                        input int pulse_at, input int rst_at);
    d_cyc = -1; w_cnt = 0; w_cyc = -1; d_err = 1'b0; w_dat = 64'd0; b_after = 1'b1;
    @(negedge clk);
    bus.req = 1'b1; bus.we = we; bus.func3 = f3; bus.addr = a; bus.wdata = wd;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      bus.req = (c == pulse_at);
      if (c == pulse_at) begin
        bus.we = 1'b1; bus.func3 = 3'b011; bus.addr = 64'h118; bus.wdata = 64'hDEAD;
      end
      reset = (c == rst_at);
      if (c == rst_at + 1) b_after = bus.busy;
      if (bus.mem_wr) begin w_cnt++; w_cyc = c; w_dat = bus.mem_wdata; end
      if (bus.done) begin d_cyc = c; d_err = bus.err; break; end
    end
    if (d_cyc > 0) begin
      @(negedge clk);
      b_after = bus.busy;
    end
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 64'd0;
    mem[32] = 64'h8877665544332211;
    bus.req = 1'b0; bus.we = 1'b0; bus.func3 = 3'd0; bus.addr = 64'd0; bus.wdata = 64'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    check("rst_rdata", bus.rdata, 64'd0);
    check("rst_mem_wr", 64'(bus.mem_wr), 64'd0);
    check("rst_mem_addr", bus.mem_addr, 64'd0);
    check("rst_mem_wdata", bus.mem_wdata, 64'd0);
    reset = 1'b0;
    access(1'b0, 3'b011, 64'h100, 64'd0, -1, -1);
    check("ld_done_cyc", 64'(d_cyc), 64'd4);
    check("ld_rdata", bus.rdata, 64'h8877665544332211);
    check("ld_err", 64'(d_err), 64'd0);
    check("ld_no_wr", 64'(w_cnt), 64'd0);
    check("ld_busy_after", 64'(b_after), 64'd0);
    access(1'b0, 3'b000, 64'h107, 64'd0, -1, -1);
    check("lb_rdata", bus.rdata, 64'hFFFFFFFFFFFFFF88);
    access(1'b0, 3'b100, 64'h107, 64'd0, -1, -1);
    check("lbu_rdata", bus.rdata, 64'h0000000000000088);
    access(1'b0, 3'b001, 64'h106, 64'd0, -1, -1);
    check("lh_rdata", bus.rdata, 64'hFFFFFFFFFFFF8877);
    access(1'b0, 3'b110, 64'h104, 64'd0, -1, -1);
    check("lwu_rdata", bus.rdata, 64'h0000000088776655);
    access(1'b0, 3'b010, 64'h104, 64'd0, -1, -1);
    check("lw_rdata", bus.rdata, 64'hFFFFFFFF88776655);
    access(1'b0, 3'b101, 64'h102, 64'd0, -1, -1);
    check("lhu_rdata", bus.rdata, 64'h0000000000004433);
    access(1'b1, 3'b001, 64'h102, 64'hAAAABBBB, -1, -1);
    check("sh_wr_cyc", 64'(w_cyc), 64'd4);
    check("sh_wr_cnt", 64'(w_cnt), 64'd1);
    check("sh_wdata", w_dat, 64'h88776655BBBB2211);
    check("sh_done_cyc", 64'(d_cyc), 64'd5);
    check("sh_err", 64'(d_err), 64'd0);
    check("sh_rdata_kept", bus.rdata, 64'h0000000000004433);
    check("sh_mem", mem[32], 64'h88776655BBBB2211);
    access(1'b1, 3'b000, 64'h105, 64'h12345678_000000CC, -1, -1);
    check("sb_wdata", w_dat, 64'h8877CC55BBBB2211);
    check("sb_done_cyc", 64'(d_cyc), 64'd5);
    access(1'b1, 3'b011, 64'h108, 64'h0123456789ABCDEF, -1, -1);
    check("sd_wr_cyc", 64'(w_cyc), 64'd1);
    check("sd_wr_cnt", 64'(w_cnt), 64'd1);
    check("sd_wdata", w_dat, 64'h0123456789ABCDEF);
    check("sd_done_cyc", 64'(d_cyc), 64'd2);
    access(1'b0, 3'b010, 64'h102, 64'd0, -1, -1);
    check("lw_mis_done_cyc", 64'(d_cyc), 64'd1);
    check("lw_mis_err", 64'(d_err), 64'd1);
    check("lw_mis_no_wr", 64'(w_cnt), 64'd0);
    check("lw_mis_rdata_kept", bus.rdata, 64'h0000000000004433);
    access(1'b1, 3'b100, 64'h100, 64'hFFFF, -1, -1);
    check("st_ill_done_cyc", 64'(d_cyc), 64'd1);
    check("st_ill_err", 64'(d_err), 64'd1);
    check("st_ill_no_wr", 64'(w_cnt), 64'd0);
    check("st_ill_mem", mem[32], 64'h8877CC55BBBB2211);
    access(1'b0, 3'b011, 64'h108, 64'd0, 2, -1);
    check("busy_req_done_cyc", 64'(d_cyc), 64'd4);
    check("busy_req_rdata", bus.rdata, 64'h0123456789ABCDEF);
    check("busy_req_no_wr", 64'(w_cnt), 64'd0);
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.done || bus.mem_wr || bus.busy) extra++;
    end
    check("busy_req_ignored", 64'(extra), 64'd0);
    check("busy_req_mem", mem[35], 64'd0);
    access(1'b1, 3'b001, 64'h100, 64'h7777, -1, 2);
    check("rst_mid_no_done", 64'(d_cyc), 64'hFFFFFFFFFFFFFFFF);
    check("rst_mid_no_wr", 64'(w_cnt), 64'd0);
    check("rst_mid_busy", 64'(b_after), 64'd0);
    check("rst_mid_mem", mem[32], 64'h8877CC55BBBB2211);
    check("rst_mid_rdata", bus.rdata, 64'd0);
    access(1'b0, 3'b011, 64'h100, 64'd0, -1, -1);
    check("post_rst_done_cyc", 64'(d_cyc), 64'd4);
    check("post_rst_rdata", bus.rdata, 64'h8877CC55BBBB2211);
    check("post_rst_err", 64'(d_err), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multi-cycle load/store responder between the control unit's memory-access states and the 64-bit data memory. It accepts one load or store request at a time and performs sub-doubleword stores as read-modify-write. Loads come back aligned and sign- or zero-extended. Completion is reported with a one-cycle `done` pulse, so the FSM can wait on `done` instead of a fixed number of cycles.

## Interface
- `READ_LAT`, default 1: memory read latency in cycles, legal range 1..4.

- `clk` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in 1: request strobe; sampled only in IDLE.
- `we` in 1: 1 = store, 0 = load.
- `func3` in 3: RV64 width code (see Operation).
- `addr` in 64: byte address.
- `wdata` in 64: store data, right-aligned.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid with `done`; 1 = misaligned or illegal request.
- `rdata` out 64: extended load result; holds until the next successful load completes.
- `mem_addr` out 64: doubleword-aligned address, `{addr_q[63:3],3'b000}`.
- `mem_wr` out 1: memory write enable.
- `mem_wdata` out 64: write data (merged for narrow stores).
- `mem_rdata` in 64: memory read data; valid READ_LAT cycles after `mem_addr` is first presented, as long as `mem_addr` is held.

## Operation
- **Load `func3` codes:** 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu; 111 is illegal.
- **Store `func3` codes:** 000 sb, 001 sh, 010 sw, 011 sd; `func3[2]=1` is illegal.
- **Alignment:** h requires `addr[0]=0`, w requires `addr[1:0]=0`, d requires `addr[2:0]=0`. Byte access is always aligned.
- **Byte order:** little-endian; byte lane = `addr_q[2:0]`.
- **Capture:** on `req` in IDLE, latch `we`, `func3`, `addr`, `wdata`.
- **States:**
  - IDLE: if `req` and illegal/misaligned → ERR; if `req` and sd → WRITE; if `req` otherwise → RD_WAIT.
  - RD_WAIT: held for READ_LAT+1 cycles (down-counter). `mem_rdata` is sampled at the edge ending the last cycle. Then a load → DONE (`rdata` updated at the same edge); a narrow store → WRITE (merged word registered at the same edge).
  - WRITE: `mem_wr=1` for exactly one cycle, then → DONE.
  - DONE: `done=1`, `err=0`, then → IDLE.
  - ERR: `done=1`, `err=1`, no memory access at all, then → IDLE.
- **Extraction:** lanes are selected from the sampled doubleword. lb/lh/lw sign-extend from bit 7/15/31; lbu/lhu/lwu zero-extend.
- **Merge:** replace only the addressed 1/2/4 bytes with `wdata[7:0]`/`[15:0]`/`[31:0]`. All other bytes keep their read value. For sd, `mem_wdata = wdata_q`.
- **Unused outputs:** `mem_wdata` and `mem_addr` are don't-care when not in use, but `mem_wr` must be 0 in every state except WRITE.

## Timing
- **Reset values:** `busy=0`, `done=0`, `err=0`, `rdata=0`, `mem_wr=0`, `mem_addr=0`, `mem_wdata=0`; state IDLE, counter 0.
- **Latency from the `req` cycle (cycle 0) to the `done` cycle:**
  - load: READ_LAT+2
  - narrow store: READ_LAT+3
  - sd: 2
  - error: 1
- **`busy`:** rises in cycle 1 and falls in the cycle after `done`. `req` with `busy=1` is ignored, with no queueing.
- **Back-to-back requests:** `req` is accepted in the first IDLE cycle after DONE. `req` held high across DONE starts exactly one new access on that IDLE cycle.
- **`mem_addr`:** stable from cycle 1 through the end of WRITE.
- **Reset mid-operation:** the state returns to IDLE at that edge and `mem_wr=0` from the next cycle; no `done` is issued. A write already in WRITE is committed by memory at that same edge (same-edge semantics).
- **`rdata` retention:** unchanged by stores, errors and reset-free idle cycles.

## Test plan
All scenarios use READ_LAT=2.
1. ld: mem[0x100] = 0x8877665544332211, `addr=0x100`, `func3=011` → `done` at cycle 4, `rdata=0x8877665544332211`, `err=0`, `mem_wr` never high.
2. lb/lbu: same memory word, `addr=0x107`; `func3=000` → `rdata=0xFFFFFFFFFFFFFF88`; `func3=100` → `0x0000000000000088`; lh at `addr=0x106` → `0xFFFFFFFFFFFF8877`.
3. sh: `addr=0x102`, `wdata=0xAAAABBBB`, memory word as in 1 → `mem_wr` high only at cycle 4 with `mem_wdata=0x88776655BBBB2211`, `done` at cycle 5.
4. sd: `addr=0x108`, `wdata=0x0123456789ABCDEF` → `mem_wr` at cycle 1 with that data, `done` at cycle 2, no read phase.
5. Errors: lw at `addr=0x102` → `done` with `err=1` at cycle 1 and no memory activity. Store with `func3=100` → same response. `rdata` unchanged.
6. Robustness: `req` pulsed while busy → ignored. Reset asserted at cycle 2 of a narrow store → no `mem_wr`, no `done`, `busy=0` next cycle. A following ld completes normally.
